id_ex: RTL and testbench

- Pipeline register between the ID and EX stages of the 5-stage 32-bit CPU.
- Captures the decoded operands and control bundle that ID produces each cycle, and presents them to EX, MEM and WB one cycle later.
- It is the receiving end of the ID output interface.
- Implements hold on stall, bubble insertion when ID pauses for a load-use hazard, and flush.
- Keeps valid and bubble bookkeeping for the ID/EX forwarding paths and for performance counting.

---
 rtl/id_ex_pkg.sv | 44 ++++
 rtl/id_ex_counter.sv | 18 +
 rtl/id_ex.sv | 102 ++++++++++
 tb/tb_id_ex.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared decode constants for the ID/EX boundary: default control values,
// enable levels and stall-vector bit positions, as used by the decoder.
package id_ex_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [3:0] DEFAULT_ALUoperation = 4'd0;
    localparam logic [1:0] DEFAULT_ALUdata2Src  = 2'd0;
    localparam logic       DEFAULT_ALUToReg     = DISABLE;
    localparam logic [2:0] DEFAULT_memOp        = 3'd0;
    localparam logic       DEFAULT_MemToReg     = DISABLE;
    localparam logic       DEFAULT_RegWrite     = DISABLE;
    localparam logic [4:0] DEFAULT_WriteRegDst  = 5'd0;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src;
        logic       alu_to_reg;
        logic [2:0] mem_op;
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] dst;
    } ctrl_t;

    // A bubble must never write back: every writeback enable stays at its default.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op:     DEFAULT_ALUoperation,
        alu_src:    DEFAULT_ALUdata2Src,
        alu_to_reg: DEFAULT_ALUToReg,
        mem_op:     DEFAULT_memOp,
        mem_to_reg: DEFAULT_MemToReg,
        reg_write:  DEFAULT_RegWrite,
        dst:        DEFAULT_WriteRegDst
    };

endpackage

// File: rtl/id_ex_counter.sv
// Free-running wrapping event counter with synchronous reset and enable.
module id_ex_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register: latches decoded operands and control, with hold,
// load-use bubble insertion, flush, and bubble/issue bookkeeping.
module id_ex
    import id_ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] pcPlusOne_i,
    input  logic [DATA_W-1:0] regData1_i,
    input  logic [DATA_W-1:0] regData2_i,
    input  logic [DATA_W-1:0] immNumber_i,
    input  logic [3:0]        ALUoperation_i,
    input  logic [1:0]        ALUdata2Src_i,
    input  logic              ALUToReg_i,
    input  logic [2:0]        memOp_i,
    input  logic              MemToReg_i,
    input  logic              RegWrite_i,
    input  logic [4:0]        WriteRegDst_i,
    output logic [DATA_W-1:0] pcPlusOne_o,
    output logic [DATA_W-1:0] regData1_o,
    output logic [DATA_W-1:0] regData2_o,
    output logic [DATA_W-1:0] immNumber_o,
    output logic [3:0]        ALUoperation_o,
    output logic [1:0]        ALUdata2Src_o,
    output logic              ALUToReg_o,
    output logic [2:0]        memOp_o,
    output logic              MemToReg_o,
    output logic              RegWrite_o,
    output logic [4:0]        WriteRegDst_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubbleCount_o,
    output logic [CNT_W-1:0]  issueCount_o
);

    ctrl_t ctrl_q;
    ctrl_t ctrl_in;
    logic  bubble_stall;
    logic  advance;
    logic  unused_stall_bits;

    assign ctrl_in = '{
        alu_op:     ALUoperation_i,
        alu_src:    ALUdata2Src_i,
        alu_to_reg: ALUToReg_i,
        mem_op:     memOp_i,
        mem_to_reg: MemToReg_i,
        reg_write:  RegWrite_i,
        dst:        WriteRegDst_i
    };

    assign bubble_stall = stall_i[STALL_ID] && !stall_i[STALL_EX];
    assign advance      = !stall_i[STALL_ID];
    assign unused_stall_bits = ^{stall_i[STALL_WB], stall_i[STALL_MEM],
                                 stall_i[STALL_IF], stall_i[STALL_PC]};

    // Reset, flush and load-use bubble all load the same bubble contents.
    always_ff @(posedge clk) begin
        if (rst || flush_i || bubble_stall) begin
            pcPlusOne_o <= '0;
            regData1_o  <= '0;
            regData2_o  <= '0;
            immNumber_o <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            valid_o     <= 1'b0;
        end else if (advance) begin
            pcPlusOne_o <= pcPlusOne_i;
            regData1_o  <= regData1_i;
            regData2_o  <= regData2_i;
            immNumber_o <= immNumber_i;
            ctrl_q      <= ctrl_in;
            valid_o     <= 1'b1;
        end
    end

    assign ALUoperation_o = ctrl_q.alu_op;
    assign ALUdata2Src_o  = ctrl_q.alu_src;
    assign ALUToReg_o     = ctrl_q.alu_to_reg;
    assign memOp_o        = ctrl_q.mem_op;
    assign MemToReg_o     = ctrl_q.mem_to_reg;
    assign RegWrite_o     = ctrl_q.reg_write;
    assign WriteRegDst_o  = ctrl_q.dst;

    id_ex_counter #(.CNT_W(CNT_W)) u_bubble_count (
        .clk   (clk),
        .rst   (rst),
        .en    (!flush_i && bubble_stall),
        .count (bubbleCount_o)
    );

    id_ex_counter #(.CNT_W(CNT_W)) u_issue_count (
        .clk   (clk),
        .rst   (rst),
        .en    (!flush_i && advance),
        .count (issueCount_o)
    );

endmodule

// File: tb/tb_id_ex.sv
// Directed and randomized checks of the ID/EX register against a behavioural
// model of the priority rules, using a narrow counter to exercise wrap-around.
module tb_id_ex;
    import id_ex_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall_i;
    logic          flush_i;
    logic [DW-1:0] pc_i, r1_i, r2_i, imm_i;
    logic [3:0]    aluop_i;
    logic [1:0]    src_i;
    logic          a2r_i, m2r_i, rw_i;
    logic [2:0]    memop_i;
    logic [4:0]    dst_i;

    logic [DW-1:0] pc_o, r1_o, r2_o, imm_o;
    logic [3:0]    aluop_o;
    logic [1:0]    src_o;
    logic          a2r_o, m2r_o, rw_o, valid_o;
    logic [2:0]    memop_o;
    logic [4:0]    dst_o;
    logic [CW-1:0] bub_o, iss_o;

    int total = 0;
    int bad   = 0;

    // Reference state: outputs as a flat record plus unbounded event counts.
    logic [4*DW-1:0] e_data;
    logic [16:0]     e_ctrl;
    logic            e_valid;
    int unsigned     n_bubbles, n_issued;

    always #5 clk = ~clk;

    id_ex #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .pcPlusOne_i(pc_i), .regData1_i(r1_i), .regData2_i(r2_i), .immNumber_i(imm_i),
        .ALUoperation_i(aluop_i), .ALUdata2Src_i(src_i), .ALUToReg_i(a2r_i),
        .memOp_i(memop_i), .MemToReg_i(m2r_i), .RegWrite_i(rw_i), .WriteRegDst_i(dst_i),
        .pcPlusOne_o(pc_o), .regData1_o(r1_o), .regData2_o(r2_o), .immNumber_o(imm_o),
        .ALUoperation_o(aluop_o), .ALUdata2Src_o(src_o), .ALUToReg_o(a2r_o),
        .memOp_o(memop_o), .MemToReg_o(m2r_o), .RegWrite_o(rw_o), .WriteRegDst_o(dst_o),
        .valid_o(valid_o), .bubbleCount_o(bub_o), .issueCount_o(iss_o)
    );

    function automatic logic [16:0] bubble_ctrl();
        return {DEFAULT_ALUoperation, DEFAULT_ALUdata2Src, DEFAULT_ALUToReg,
                DEFAULT_memOp, DEFAULT_MemToReg, DEFAULT_RegWrite, DEFAULT_WriteRegDst};
    endfunction

    task automatic rand_inputs();
        pc_i = $urandom; r1_i = $urandom; r2_i = $urandom; imm_i = $urandom;
        aluop_i = 4'($urandom); src_i = 2'($urandom); a2r_i = 1'($urandom);
        memop_i = 3'($urandom); m2r_i = 1'($urandom); rw_i = 1'($urandom);
        dst_i = 5'($urandom);
    endtask

    // Legal controller patterns only: a stalled stage also stalls everything upstream.
    task automatic rand_ctrl();
        case ($urandom_range(0, 4))
            0, 1: stall_i = 6'b000000;
            2:    stall_i = 6'b000111;
            3:    stall_i = 6'b001111;
            default: stall_i = 6'b111111;
        endcase
        flush_i = ($urandom_range(0, 7) == 0);
    endtask

    // Applies one clock edge to the reference using the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            e_data = '0; e_ctrl = bubble_ctrl(); e_valid = 1'b0;
            n_bubbles = 0; n_issued = 0;
        end else if (flush_i) begin
            e_data = '0; e_ctrl = bubble_ctrl(); e_valid = 1'b0;
        end else if (stall_i[2] && !stall_i[3]) begin
            e_data = '0; e_ctrl = bubble_ctrl(); e_valid = 1'b0;
            n_bubbles++;
        end else if (!stall_i[2]) begin
            e_data = {pc_i, r1_i, r2_i, imm_i};
            e_ctrl = {aluop_i, src_i, a2r_i, memop_i, m2r_i, rw_i, dst_i};
            e_valid = 1'b1;
            n_issued++;
        end
    endtask

    task automatic check(input string tag);
        logic [4*DW-1:0] got_data;
        logic [17:0]     got_ctrl;
        logic [2*CW-1:0] got_cnt, exp_cnt;
        got_data = {pc_o, r1_o, r2_o, imm_o};
        got_ctrl = {aluop_o, src_o, a2r_o, memop_o, m2r_o, rw_o, dst_o, valid_o};
        got_cnt  = {bub_o, iss_o};
        exp_cnt  = {CW'(n_bubbles % (1 << CW)), CW'(n_issued % (1 << CW))};
        total++;
        assert (got_data === e_data) else begin
            bad++;
            $error("FAIL %s data: got %h expected %h", tag, got_data, e_data);
        end
        total++;
        assert (got_ctrl === {e_ctrl, e_valid}) else begin
            bad++;
            $error("FAIL %s ctrl/valid: got %h expected %h", tag, got_ctrl, {e_ctrl, e_valid});
        end
        total++;
        assert (got_cnt === exp_cnt) else begin
            bad++;
            $error("FAIL %s counters: got %h expected %h", tag, got_cnt, exp_cnt);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        e_data = 'x; e_ctrl = 'x; e_valid = 1'bx; n_bubbles = 0; n_issued = 0;

        // Reset for two cycles with random inputs.
        rst = 1'b1; rand_inputs(); rand_ctrl();
        step("reset0");
        rand_inputs(); rand_ctrl();
        step("reset1");

        // Pass-through.
        rst = 1'b0; flush_i = 1'b0; stall_i = 6'b000000; rand_inputs();
        pc_i = 32'h10; r1_i = 32'hA5A5A5A5; dst_i = 5'd8; rw_i = 1'b1;
        step("pass");
        expect_val("pass_pc", pc_o, 32'h10);
        expect_val("pass_r1", r1_o, 32'hA5A5A5A5);
        expect_val("pass_dst", 32'(dst_o), 32'd8);
        expect_val("pass_valid", 32'(valid_o), 32'd1);
        expect_val("pass_issue", 32'(iss_o), 32'd1);

        // Load-use bubble, then normal latch.
        rand_inputs(); stall_i = 6'b000111; m2r_i = 1'b1; dst_i = 5'd3; rw_i = 1'b1;
        step("loaduse");
        expect_val("bubble_rw", 32'(rw_o), 32'd0);
        expect_val("bubble_m2r", 32'(m2r_o), 32'd0);
        expect_val("bubble_dst", 32'(dst_o), 32'd0);
        expect_val("bubble_count", 32'(bub_o), 32'd1);
        rand_inputs(); stall_i = 6'b000000;
        step("after_bubble");

        // Hold across three full stalls with changing inputs.
        rand_inputs();
        step("pre_hold");
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); stall_i = 6'b001111;
            step($sformatf("hold%0d", i));
        end

        // Flush wins over a bubble stall.
        rand_inputs(); stall_i = 6'b000111; flush_i = 1'b1;
        step("flush_stall");
        flush_i = 1'b0;

        // Counter wrap after reset: 17 issues leave the 4-bit count at 1.
        rst = 1'b1; step("wrap_reset");
        rst = 1'b0; stall_i = 6'b000000;
        for (int i = 0; i < 17; i++) begin
            rand_inputs();
            step($sformatf("issue%0d", i));
        end
        expect_val("wrap_issue", 32'(iss_o), 32'd1);
        rand_inputs(); stall_i = 6'b000111;
        step("bubble_pre_rst");
        rand_inputs(); rand_ctrl(); rst = 1'b1;
        step("mid_reset");
        expect_val("mid_reset_cnt", 32'({bub_o, iss_o}), 32'd0);
        rst = 1'b0;

        // Randomized run with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(); rand_ctrl();
            rst = ($urandom_range(0, 63) == 0);
            step($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
